// File: rtl/lidar_symbol_unpacker.sv
// Serialises a validated 512-bit payload MSB-first into SYM_W-bit symbols.
// Frames that carry a CRC error or an illegal size are dropped and counted.
module lidar_symbol_unpacker #(
    parameter int unsigned SYM_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_valid,
    input  logic [511:0]           encoded_data,
    input  logic [9:0]             data_size,
    input  logic [15:0]            point_count,
    input  logic                   crc_error,
    output logic                   in_ready,
    output logic                   sym_valid,
    input  logic                   sym_ready,
    output logic [SYM_W-1:0]       sym_data,
    output logic [$clog2(SYM_W):0] sym_bits,
    output logic                   sym_first,
    output logic                   sym_last,
    output logic [15:0]            frame_points,
    output logic                   drop_pulse,
    output logic [15:0]            frames_ok,
    output logic [15:0]            frames_dropped
);

    localparam int unsigned BW = $clog2(SYM_W) + 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [511:0] shreg_q, shreg_d;
    logic [9:0]   remaining_q, remaining_d;
    logic         first_q, first_d;
    logic [15:0]  frame_points_q, frame_points_d;
    logic         drop_pulse_q, drop_pulse_d;
    logic [15:0]  frames_ok_q, frames_ok_d;
    logic [15:0]  frames_dropped_q, frames_dropped_d;

    logic          accept;
    logic          illegal;
    logic          last_sym;
    logic [BW-1:0] cur_bits;
    logic [SYM_W-1:0] keep_mask;

    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = data_valid && in_ready;
    assign illegal  = crc_error || (data_size == 10'd0) || (data_size > 10'd512);
    assign last_sym = (remaining_q <= 10'(SYM_W));

    // Only the top cur_bits of the symbol are payload; the rest is zeroed.
    assign cur_bits  = last_sym ? remaining_q[BW-1:0] : BW'(SYM_W);
    assign keep_mask = ~({SYM_W{1'b1}} >> cur_bits);

    always_comb begin
        state_d          = state_q;
        shreg_d          = shreg_q;
        remaining_d      = remaining_q;
        first_d          = first_q;
        frame_points_d   = frame_points_q;
        drop_pulse_d     = 1'b0;
        frames_ok_d      = frames_ok_q;
        frames_dropped_d = frames_dropped_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        drop_pulse_d = 1'b1;
                        if (frames_dropped_q != 16'hFFFF)
                            frames_dropped_d = frames_dropped_q + 16'd1;
                    end else begin
                        shreg_d        = encoded_data;
                        remaining_d    = data_size;
                        frame_points_d = point_count;
                        first_d        = 1'b1;
                        state_d        = EMIT;
                    end
                end
            end
            EMIT: begin
                if (sym_ready) begin
                    shreg_d = shreg_q << SYM_W;
                    first_d = 1'b0;
                    if (last_sym) begin
                        remaining_d = '0;
                        state_d     = IDLE;
                        if (frames_ok_q != 16'hFFFF)
                            frames_ok_d = frames_ok_q + 16'd1;
                    end else begin
                        remaining_d = remaining_q - 10'(SYM_W);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            shreg_q          <= '0;
            remaining_q      <= '0;
            first_q          <= 1'b0;
            frame_points_q   <= '0;
            drop_pulse_q     <= 1'b0;
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
        end else begin
            state_q          <= state_d;
            shreg_q          <= shreg_d;
            remaining_q      <= remaining_d;
            first_q          <= first_d;
            frame_points_q   <= frame_points_d;
            drop_pulse_q     <= drop_pulse_d;
            frames_ok_q      <= frames_ok_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    assign sym_valid      = (state_q == EMIT);
    assign sym_data       = sym_valid ? (shreg_q[511 -: SYM_W] & keep_mask) : '0;
    assign sym_bits       = sym_valid ? cur_bits : '0;
    assign sym_first      = sym_valid && first_q;
    assign sym_last       = sym_valid && last_sym;
    assign frame_points   = frame_points_q;
    assign drop_pulse     = drop_pulse_q;
    assign frames_ok      = frames_ok_q;
    assign frames_dropped = frames_dropped_q;

endmodule

// File: tb/tb_lidar_symbol_unpacker.sv
// Scoreboard bench for lidar_symbol_unpacker: directed plan cases plus randomized frames.
module tb_lidar_symbol_unpacker;

    localparam int unsigned SYM_W = 16;
    localparam int unsigned BW    = $clog2(SYM_W) + 1;

    logic             clk;
    logic             reset;
    logic             data_valid;
    logic [511:0]     encoded_data;
    logic [9:0]       data_size;
    logic [15:0]      point_count;
    logic             crc_error;
    logic             in_ready;
    logic             sym_valid;
    logic             sym_ready;
    logic [SYM_W-1:0] sym_data;
    logic [BW-1:0]    sym_bits;
    logic             sym_first;
    logic             sym_last;
    logic [15:0]      frame_points;
    logic             drop_pulse;
    logic [15:0]      frames_ok;
    logic [15:0]      frames_dropped;

    lidar_symbol_unpacker #(.SYM_W(SYM_W)) dut (
        .clk(clk), .reset(reset), .data_valid(data_valid), .encoded_data(encoded_data),
        .data_size(data_size), .point_count(point_count), .crc_error(crc_error),
        .in_ready(in_ready), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_data(sym_data), .sym_bits(sym_bits), .sym_first(sym_first),
        .sym_last(sym_last), .frame_points(frame_points), .drop_pulse(drop_pulse),
        .frames_ok(frames_ok), .frames_dropped(frames_dropped)
    );

    typedef struct {
        logic [SYM_W-1:0] data;
        int unsigned      bits;
        bit               first;
        bit               last;
        logic [15:0]      pts;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned hs_count = 0;
    int          rdy_mode = 0;
    int unsigned exp_ok = 0;
    int unsigned exp_drop = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: symbol i covers payload bits [511-i*W downto ...], MSB-first.
    function automatic void push_frame(input logic [511:0] d, input int unsigned sz,
                                       input logic [15:0] pts);
        int unsigned nsym;
        nsym = (sz + SYM_W - 1) / SYM_W;
        for (int unsigned i = 0; i < nsym; i++) begin
            exp_t e;
            e.bits  = (sz - i * SYM_W < SYM_W) ? sz - i * SYM_W : SYM_W;
            e.data  = '0;
            for (int unsigned b = 0; b < e.bits; b++)
                e.data[SYM_W-1-b] = d[511 - i * SYM_W - b];
            e.first = (i == 0);
            e.last  = (i == nsym - 1);
            e.pts   = pts;
            exp_q.push_back(e);
        end
    endfunction

    // Downstream ready generator: 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
    initial begin
        int unsigned ph;
        ph = 0;
        sym_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: sym_ready = 1'b1;
                1: begin sym_ready = (ph % 3 == 0); ph++; end
                default: sym_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every presented symbol is checked against the queue head, stalled or not.
    always @(negedge clk) begin
        if (!reset && sym_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sym_valid", 64'(sym_valid), 64'd0);
            end else begin
                chk("sym_data",     64'(sym_data),     64'(exp_q[0].data));
                chk("sym_bits",     64'(sym_bits),     64'(exp_q[0].bits));
                chk("sym_first",    64'(sym_first),    64'(exp_q[0].first));
                chk("sym_last",     64'(sym_last),     64'(exp_q[0].last));
                chk("frame_points", 64'(frame_points), 64'(exp_q[0].pts));
                if (sym_ready) begin
                    void'(exp_q.pop_front());
                    hs_count++;
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},       64'(in_ready),       64'd0);
        chk({tag, "_sym_valid"},      64'(sym_valid),      64'd0);
        chk({tag, "_sym_data"},       64'(sym_data),       64'd0);
        chk({tag, "_sym_bits"},       64'(sym_bits),       64'd0);
        chk({tag, "_sym_first"},      64'(sym_first),      64'd0);
        chk({tag, "_sym_last"},       64'(sym_last),       64'd0);
        chk({tag, "_frame_points"},   64'(frame_points),   64'd0);
        chk({tag, "_drop_pulse"},     64'(drop_pulse),     64'd0);
        chk({tag, "_frames_ok"},      64'(frames_ok),      64'd0);
        chk({tag, "_frames_dropped"}, 64'(frames_dropped), 64'd0);
    endtask

    // Presents one payload, waits for acceptance, and checks the cycle after accept.
    task automatic send_frame(input logic [511:0] d, input logic [9:0] sz,
                              input logic [15:0] pts, input bit crc);
        int unsigned n;
        bit legal;
        n = 0;
        @(posedge clk);
        #1;
        while (!in_ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        legal = !crc && sz != 10'd0 && sz <= 10'd512;
        data_valid   = 1'b1;
        encoded_data = d;
        data_size    = sz;
        point_count  = pts;
        crc_error    = crc;
        if (legal) begin
            push_frame(d, int'(sz), pts);
            exp_ok++;
        end else begin
            exp_drop++;
        end
        @(posedge clk);
        #1;
        data_valid   = 1'b0;
        crc_error    = 1'b0;
        encoded_data = {16{$urandom}};
        @(negedge clk);
        if (legal) begin
            chk("latency_sym_valid", 64'(sym_valid), 64'd1);
            chk("latency_in_ready",  64'(in_ready),  64'd0);
            chk("no_drop_pulse",     64'(drop_pulse), 64'd0);
        end else begin
            chk("drop_pulse_hi",    64'(drop_pulse), 64'd1);
            chk("drop_no_valid",    64'(sym_valid),  64'd0);
            chk("drop_in_ready",    64'(in_ready),   64'd1);
            @(negedge clk);
            chk("drop_pulse_lo",    64'(drop_pulse), 64'd0);
        end
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n < 5000), 64'd1);
        @(negedge clk);
        chk("frames_ok",      64'(frames_ok),      64'(exp_ok));
        chk("frames_dropped", 64'(frames_dropped), 64'(exp_drop));
    endtask

    function automatic logic [511:0] rand_payload();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [511:0] full_d;
        logic [511:0] d;
        int unsigned  base;
        int unsigned  n;
        int unsigned  r;
        logic [9:0]   sz;

        reset = 1'b1;
        data_valid = 1'b0;
        encoded_data = '0;
        data_size = '0;
        point_count = '0;
        crc_error = 1'b0;
        for (int k = 0; k < 32; k++) full_d[511 - 16*k -: 16] = 16'(k + 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Full 512-bit frame at one symbol per cycle.
        rdy_mode = 0;
        base = hs_count;
        send_frame(full_d, 10'd512, 16'd100, 1'b0);
        repeat (31) @(posedge clk);
        #1;
        chk("full_busy_before_last", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("full_in_ready_after_last", 64'(in_ready), 64'd1);
        wait_idle();
        chk("full_hs_count", 64'(hs_count - base), 64'd32);

        // Partial last symbol with garbage in the unused low bits.
        d = rand_payload();
        d[511 -: 32] = 32'hABCD_F5A5;
        send_frame(d, 10'd20, 16'd7, 1'b0);
        wait_idle();

        // Backpressure 1,0,0 over a full frame.
        rdy_mode = 1;
        base = hs_count;
        send_frame(full_d, 10'd512, 16'd100, 1'b0);
        wait_idle();
        chk("bp_hs_count", 64'(hs_count - base), 64'd32);

        // Drops: CRC error, zero size, oversize.
        rdy_mode = 0;
        send_frame(full_d, 10'd512, 16'd1, 1'b1);
        send_frame(full_d, 10'd0,   16'd2, 1'b0);
        send_frame(full_d, 10'd600, 16'd3, 1'b0);
        wait_idle();

        // Reset after symbol 5 of a stalled frame.
        rdy_mode = 1;
        base = hs_count;
        send_frame(full_d, 10'd512, 16'd55, 1'b0);
        n = 0;
        while (hs_count < base + 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reset_mid_wait", 64'(hs_count >= base + 5), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset_vals("midreset");
        reset = 1'b0;
        exp_ok = 0;
        exp_drop = 0;
        @(negedge clk);
        chk("in_ready_after_midreset", 64'(in_ready), 64'd1);
        rdy_mode = 0;
        send_frame(full_d, 10'd512, 16'd77, 1'b0);
        wait_idle();

        // Randomized frames, drops and backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: sz = 10'($urandom_range(1, 512));
                1: sz = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(513, 1023));
                2: sz = 10'd1;
                3: sz = 10'(SYM_W);
                4: sz = 10'(SYM_W + 1);
                5: sz = 10'd512;
                default: sz = 10'($urandom_range(1, 512));
            endcase
            send_frame(rand_payload(), sz, 16'($urandom), r == 0);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
